// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes from issue to writeback and stalls ID one cycle on load-use.
// stall_o is combinational from registered state; mem_stall_i freezes all state and suppresses issue.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                id_valid_i,
  input  logic [REG_W-1:0]    id_rs1_i,
  input  logic [REG_W-1:0]    id_rs2_i,
  input  logic                id_use_rs1_i,
  input  logic                id_use_rs2_i,
  input  logic [REG_W-1:0]    id_rd_i,
  input  logic                id_regwrite_i,
  input  logic                id_memread_i,
  input  logic                flush_i,
  input  logic                mem_stall_i,
  output logic                stall_o,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [CNT_W-1:0]    stall_count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_REGS-1:0]      v_q, v_d;
  logic [NUM_REGS-1:0]      l_q, l_d;
  logic [NUM_REGS-1:0][1:0] a_q, a_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic hit_rs1, hit_rs2, advance, issue;

  // Only a load still in EX cannot be bypassed; older loads and all ALU results are forwarded.
  always_comb begin
    hit_rs1 = id_use_rs1_i && (id_rs1_i != '0) && v_q[id_rs1_i] &&
              l_q[id_rs1_i] && (a_q[id_rs1_i] == 2'd0);
    hit_rs2 = id_use_rs2_i && (id_rs2_i != '0) && v_q[id_rs2_i] &&
              l_q[id_rs2_i] && (a_q[id_rs2_i] == 2'd0);
    stall_o = id_valid_i && !flush_i && (hit_rs1 || hit_rs2);
  end

  assign advance = !mem_stall_i;
  assign issue   = advance && id_valid_i && id_regwrite_i && (id_rd_i != '0) &&
                   !stall_o && !flush_i;

  always_comb begin
    v_d   = v_q;
    l_d   = l_q;
    a_d   = a_q;
    cnt_d = cnt_q;
    if (advance) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (v_q[r]) begin
          if (a_q[r] == 2'd2) begin
            v_d[r] = 1'b0;
          end else begin
            a_d[r] = a_q[r] + 2'd1;
          end
          if (flush_i && (a_q[r] == 2'd0)) begin
            v_d[r] = 1'b0;
          end
        end
      end
      // Newest producer owns the entry; the older write is safely forgotten.
      if (issue) begin
        v_d[id_rd_i] = 1'b1;
        a_d[id_rd_i] = 2'd0;
        l_d[id_rd_i] = id_memread_i;
      end
      if (stall_o && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    v_d[0] = 1'b0;
    l_d[0] = 1'b0;
    a_d[0] = 2'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q   <= '0;
      l_q   <= '0;
      a_q   <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      l_q   <= l_d;
      a_q   <= a_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy_o        = {v_q[NUM_REGS-1:1], 1'b0};
  assign stall_count_o = cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side companion to the EX-stage forwarding unit in the 5-stage RISC-V pipeline.
- The forwarding unit resolves hazards that MEM/WB bypass can satisfy. This block tracks in-flight register writes from issue until writeback and detects the load-use case that bypass cannot cover.
- On load-use it stalls PC and IF/ID for one cycle and inserts a bubble into ID/EX.
- It also publishes per-register busy status and a saturating stall-cycle counter for performance debug.

Parameters:
- NUM_REGS, 32: architectural register count. x0 is never tracked.
- REG_W, 5: register index width. Equals log2(NUM_REGS).
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk_i  input  1  pipeline clock.
- rst_i  input  1  synchronous active-high reset.
- id_valid_i  input  1  ID stage holds a valid instruction.
- id_rs1_i  input  REG_W  ID source register 1.
- id_rs2_i  input  REG_W  ID source register 2.
- id_use_rs1_i  input  1  instruction reads rs1.
- id_use_rs2_i  input  1  instruction reads rs2.
- id_rd_i  input  REG_W  ID destination register.
- id_regwrite_i  input  1  instruction writes rd.
- id_memread_i  input  1  instruction is a load.
- flush_i  input  1  squash the instructions in ID and EX (taken branch).
- mem_stall_i  input  1  data memory busy; the whole pipeline is frozen.
- stall_o  output  1  hold PC/IF-ID and bubble ID/EX.
- busy_o  output  NUM_REGS  bit r = register r has an in-flight write.
- stall_count_o  output  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- State per register r (1..NUM_REGS-1): valid bit v[r], 2-bit age a[r], load flag l[r].
  - Age 0 = producer in EX; 1 = in MEM; 2 = in WB.
  - Entry 0 is hard-wired invalid.
- Reset (rst_i=1 at a clock edge):
  - all v, a, l cleared; stall_count_o = 0.
  - stall_o = 0 in the following cycle, because it derives from cleared state.
  - Reset takes priority over every other input, including mid-stall and mid-mem_stall.
- stall_o is combinational from registered state. It is 1 iff all of:
  - id_valid_i = 1 and flush_i = 0;
  - for some used source s (rs1 with use_rs1, or rs2 with use_rs2): s != 0, v[s] = 1, l[s] = 1, a[s] = 0.
  - An ALU producer at any age never stalls. A load at age >= 1 never stalls.
- advance = !mem_stall_i. Each clock edge with advance = 1, in this order:
  1. Aging: every valid entry increments a; an entry at a = 2 becomes invalid.
  2. Flush: if flush_i = 1, every entry at a = 0 before aging is invalidated. Entries already in MEM/WB continue aging.
  3. Issue: if id_valid_i & id_regwrite_i & (id_rd_i != 0) & !stall_o & !flush_i, then v[rd] = 1, a[rd] = 0, l[rd] = id_memread_i.
- Issue overrides aging and flush results for the same rd. The newest producer owns the entry; an older in-flight write to the same rd is no longer tracked, which is safe because only age-0 loads stall.
- With mem_stall_i = 1, all state holds and no issue occurs. stall_o still reflects the held state.
- busy_o[r] = v[r]; busy_o[0] = 0 always.
- stall_count_o:
  - increments by 1 on each edge where stall_o = 1 and mem_stall_i = 0;
  - saturates at 2^CNT_W - 1;
  - clears only on reset.
- Latency:
  - A load issued at edge N stalls a dependent instruction in ID during cycle N+1 only.
  - The dependent instruction issues at edge N+2. Mem-stall cycles in between extend this 1:1.
- flush_i and stall_o can coincide only via the flush_i = 0 term, so flush forces stall_o = 0.

Test Plan:
- Load then dependent: lw x5 issues; next cycle add x6,x5,x1 in ID -> stall_o=1 for exactly 1 cycle, add issues on the following edge, stall_count_o=1, busy_o[5] clears 3 edges after lw issue.
- ALU chain: add x5 then sub x7,x5,x5 back-to-back -> stall_o never asserts, stall_count_o=0.
- x0 and unused source: lw x0, then a user of x0 -> no stall. lw x5, then an instruction with use_rs2=0 and rs2=5 -> no stall.
- Memory freeze: lw x5, dependent in ID, mem_stall_i=1 for 3 cycles -> stall_o=1 throughout, stall_count_o stays 0 until release, then becomes 1; busy_o[5] holds during freeze.
- Flush: lw x5 issues, flush_i=1 next cycle with dependent in ID -> stall_o=0, busy_o[5]=0 after the edge, no issue that cycle.
- Reset and saturation: with CNT_W=2, force 5 stall cycles -> count sticks at 3. Assert rst_i mid-stall -> busy_o=0, stall_count_o=0, stall_o=0 next cycle.
